// File: rtl/path_recorder_pkg.sv
// Shared definitions for the maze path recorder: direction and FSM
// encodings plus the default storage geometry (one move per cell of 16x16).
package path_recorder_pkg;

    localparam int DEPTH_DEFAULT = 256;
    localparam int AW_DEFAULT    = 8;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REPLAY = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/path_ram.sv
// Move storage: DEPTH x 2 bits, synchronous write, combinational read.
// Contents are deliberately not reset; the control logic owns validity.
module path_ram
    import path_recorder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem_r [DEPTH];

    // Write port: store one direction per enabled clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/path_recorder.sv
// Records the rat's path as a stack of moves (push = step, pop = backtrack)
// and replays it from the first move, one move per cycle, for the
// downstream move player. Every output is taken directly from a flop.
module path_recorder
    import path_recorder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [1:0]  dir_in,
    input  logic        clear,
    input  logic        run,
    output logic [1:0]  move,
    output logic        move_valid,
    output logic        busy,
    output logic        replay_done,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam logic [AW:0]   ONE_C     = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   ZERO_C    = {(AW+1){1'b0}};
    localparam logic [AW-1:0] IDX0_C    = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE_C = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);

    state_t        state_r, state_s;
    logic [AW:0]   count_r, count_s;
    logic [AW:0]   top_idx_s;
    logic [AW-1:0] rd_idx_r, rd_idx_s;
    logic [1:0]    move_r, move_s;
    logic          move_valid_r, move_valid_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          full_r, full_s;
    logic          empty_r, empty_s;
    logic          overflow_r, overflow_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [1:0]    rd_data_s;

    assign top_idx_s = count_r - ONE_C;

    path_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_path_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_addr_s),
        .wdata (dir_in),
        .raddr (rd_idx_r),
        .rdata (rd_data_s)
    );

    // Next-state, storage write control and next output values.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        rd_idx_s     = rd_idx_r;
        move_s       = move_r;
        move_valid_s = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        overflow_s   = overflow_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = count_r[AW-1:0];

        if (clear) begin
            state_s    = ST_IDLE;
            count_s    = ZERO_C;
            overflow_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        // Editing is suspended on the cycle replay starts.
                        rd_idx_s = IDX0_C;
                        if (!empty_r) begin
                            state_s = ST_REPLAY;
                            busy_s  = 1'b1;
                        end else begin
                            state_s = ST_FINISH;
                        end
                    end else if (push && pop && !empty_r) begin
                        // Backtrack and step in one cycle: replace the top move.
                        wr_en_s   = 1'b1;
                        wr_addr_s = top_idx_s[AW-1:0];
                    end else if (push && !full_r) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = count_r[AW-1:0];
                        count_s   = count_r + ONE_C;
                    end else if (push) begin
                        overflow_s = 1'b1;
                    end else if (pop && !empty_r) begin
                        count_s = top_idx_s;
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_REPLAY: begin
                    move_s       = rd_data_s;
                    move_valid_s = 1'b1;
                    busy_s       = 1'b1;
                    rd_idx_s     = rd_idx_r + IDX_ONE_C;
                    if ({1'b0, rd_idx_r} == top_idx_s) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_REPLAY;
                    end
                end
                ST_FINISH: begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        full_s  = (count_s == DEPTH_C);
        empty_s = (count_s == ZERO_C);
    end

    // Control, FSM and output registers; reset clears control state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            count_r      <= ZERO_C;
            rd_idx_r     <= IDX0_C;
            move_r       <= UP;
            move_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            rd_idx_r     <= rd_idx_s;
            move_r       <= move_s;
            move_valid_r <= move_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            full_r       <= full_s;
            empty_r      <= empty_s;
            overflow_r   <= overflow_s;
        end
    end

    assign move        = move_r;
    assign move_valid  = move_valid_r;
    assign busy        = busy_r;
    assign replay_done = done_r;
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_path_recorder.sv
// Bench for path_recorder: a queue-based stack model supplies the expected
// replay stream (direction and arrival cycle) to a scoreboard that a
// negedge monitor drains whenever the recorder presents a move or done.
module tb_path_recorder;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DONE  = 4;

    typedef struct {
        int val;
        int cyc;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [1:0]    dir_in = 2'b00;
    logic          clear = 1'b0;
    logic          run = 1'b0;
    logic [1:0]    move;
    logic          move_valid;
    logic          busy;
    logic          replay_done;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;

    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    path[$];
    bit    ovf = 1'b0;
    item_t exp_q[$];

    path_recorder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .dir_in      (dir_in),
        .clear       (clear),
        .run         (run),
        .move        (move),
        .move_valid  (move_valid),
        .busy        (busy),
        .replay_done (replay_done),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented move or done pulse must match the next expected event.
    always @(negedge clk) begin
        item_t it;
        if (rst_n && (move_valid || replay_done)) begin
            check("output_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                check("event_cycle", cyc, it.cyc);
                check("event_kind", replay_done ? DONE : int'(move), it.val);
                if (it.val == DONE) begin
                    check("done_no_valid", int'(move_valid), 0);
                    check("done_not_busy", int'(busy), 0);
                end else begin
                    check("move_busy", int'(busy), 1);
                end
            end
        end
    end

    task automatic check_status();
        check("count", int'(count), path.size());
        check("full", int'(full), int'(path.size() == DEPTH));
        check("empty", int'(empty), int'(path.size() == 0));
        check("overflow", int'(overflow), int'(ovf));
    endtask

    task automatic do_op(input bit p, input bit q, input logic [1:0] d);
        @(negedge clk);
        push = p; pop = q; dir_in = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
        if (p && q && path.size() > 0) path[path.size()-1] = int'(d);
        else if (p) begin
            if (path.size() < DEPTH) path.push_back(int'(d));
            else ovf = 1'b1;
        end else if (q && path.size() > 0) void'(path.pop_back());
        check_status();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; push = 1'($urandom_range(0, 1)); run = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        clear = 1'b0; push = 1'b0; run = 1'b0;
        path.delete();
        ovf = 1'b0;
        check_status();
        check("clear_valid", int'(move_valid), 0);
    endtask

    // Start a replay; edit/run requests issued while it runs must be ignored.
    task automatic do_replay();
        int k;
        int n;
        @(negedge clk);
        run = 1'b1;
        push = 1'($urandom_range(0, 1)); pop = 1'($urandom_range(0, 1));
        dir_in = 2'($urandom_range(0, 3));
        k = cyc + 1;
        n = path.size();
        foreach (path[i]) exp_q.push_back('{path[i], k + 1 + i});
        exp_q.push_back('{DONE, k + 1 + n});
        @(posedge clk);
        for (int e = 1; e <= n + 1; e++) begin
            @(negedge clk);
            push = 1'($urandom_range(0, 1)); pop = 1'($urandom_range(0, 1));
            run = 1'($urandom_range(0, 1)); dir_in = 2'($urandom_range(0, 3));
            @(posedge clk);
        end
        #1;
        push = 1'b0; pop = 1'b0; run = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("replay_drained", exp_q.size(), 0);
        exp_q.delete();
        if (n > 0) check("move_hold", int'(move), path[n-1]);
        check_status();
    endtask

    task automatic reset_mid_replay();
        int k;
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 2'($urandom_range(0, 3)));
        @(negedge clk);
        run = 1'b1;
        k = cyc + 1;
        foreach (path[i]) exp_q.push_back('{path[i], k + 1 + i});
        exp_q.push_back('{DONE, k + 1 + path.size()});
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("third_move_valid", int'(move_valid), 1);
        check("third_move_dir", int'(move), path[2]);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        path.delete();
        ovf = 1'b0;
        check("rst_valid", int'(move_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(replay_done), 0);
        check("rst_move", int'(move), 0);
        check_status();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_done", int'(replay_done), 0);
        check_status();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        #23;
        check("reset_valid", int'(move_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(replay_done), 0);
        check("reset_move", int'(move), 0);
        check_status();
        @(negedge clk);
        rst_n = 1'b1;

        // Four pushes replayed twice (path preserved across replay).
        do_op(1'b1, 1'b0, 2'b01); do_op(1'b1, 1'b0, 2'b01);
        do_op(1'b1, 1'b0, 2'b11); do_op(1'b1, 1'b0, 2'b10);
        do_replay();
        do_replay();
        do_clear();

        // Backtrack then new step.
        do_op(1'b1, 1'b0, 2'b00); do_op(1'b1, 1'b0, 2'b01);
        do_op(1'b1, 1'b0, 2'b11); do_op(1'b0, 1'b1, 2'b00);
        do_op(1'b1, 1'b0, 2'b10);
        do_replay();
        do_clear();

        // Push+pop on empty, then overwrite of the single entry; pop while empty.
        do_op(1'b0, 1'b1, 2'b00);
        do_op(1'b1, 1'b1, 2'b11);
        do_op(1'b1, 1'b1, 2'b00);
        do_replay();
        do_clear();

        // Replay of an empty path.
        do_replay();

        // Randomised editing with interleaved replays and clears.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 39);
            if (r < 16) do_op(1'b1, 1'b0, 2'($urandom_range(0, 3)));
            else if (r < 24) do_op(1'b0, 1'b1, 2'($urandom_range(0, 3)));
            else if (r < 34) do_op(1'b1, 1'b1, 2'($urandom_range(0, 3)));
            else if (r < 38) do_replay();
            else do_clear();
        end
        do_clear();

        // Fill to capacity, then one dropped push.
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 2'($urandom_range(0, 3)));
        do_op(1'b1, 1'b0, 2'b00);
        do_replay();
        do_clear();

        reset_mid_replay();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/path_recorder.md
PATH_RECORDER -- requirements
Module: path_recorder

Interface
REQ-001 Parameter: DEPTH, default 256, maximum stored moves (one per cell of a 16x16 maze).
REQ-002 Parameter: AW, default 8, log2(DEPTH); index width.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 Push  input  1  append Dir_in as a new top entry (rat steps forward).
REQ-006 Pop  input  1  discard the top entry (rat backtracks).
REQ-007 Dir_in  input  2  direction: 00 up, 01 right, 10 left, 11 down.
REQ-008 Clear  input  1  synchronous flush: empty the path and return to IDLE.
REQ-009 Run  input  1  start replay of the stored path, entry 0 first.
REQ-010 Move  output  2  replayed direction, valid only while Move_valid=1.
REQ-011 Move_valid  output  1  one stored move presented this cycle.
REQ-012 Busy  output  1  replay in progress.
REQ-013 Replay_done  output  1  single-cycle pulse when replay completes.
REQ-014 Count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-015 Full, Empty  output  1 each  Count==DEPTH, Count==0.
REQ-016 Overflow  output  1  sticky flag: a Push was dropped because the path was full.

Function
REQ-017 States: IDLE (record), REPLAY, FINISH; FSM and all outputs are registered.
REQ-018 IDLE, Push only, not Full: write Dir_in at index Count; Count+1 on the next edge.
REQ-019 IDLE, Push while Full: entry dropped; Count unchanged; Overflow set to 1.
REQ-020 IDLE, Pop only, not Empty: Count-1; Pop while Empty is ignored.
REQ-021 IDLE, Push and Pop together, not Empty: top entry overwritten with Dir_in; Count unchanged.
REQ-022 IDLE, Push and Pop together, Empty: behaves as Push alone.
REQ-023 IDLE, Run=1 and Count>0: go to REPLAY; Push and Pop are ignored that cycle.
REQ-024 Replay latency: Run sampled at edge k gives Move=entry 0 and Move_valid=1 after edge k+1.
REQ-025 REPLAY: one entry per cycle, indices 0..Count-1, no gaps; Busy=1 throughout.
REQ-026 After the last entry: go to FINISH; Move_valid=0, Busy=0, Replay_done=1 for exactly one cycle; then return to IDLE.
REQ-027 IDLE, Run=1 and Count==0: go directly to FINISH; Replay_done pulses with no Move_valid.
REQ-028 Stored path and Count are preserved across replay, so a later Run replays the identical sequence.
REQ-029 Push, Pop and Run are ignored in REPLAY and FINISH.
REQ-030 Clear has priority over every other input in any state: Count=0, Overflow=0, next state IDLE, Move_valid=0 on the next edge.
REQ-031 Move holds its last value when Move_valid=0.

Reset
REQ-032 RST=0 forces, immediately and asynchronously: state IDLE, Count=0, Overflow=0, Move=00, Move_valid=0, Busy=0, Replay_done=0.
REQ-033 Reset mid-replay aborts the replay with no Replay_done pulse; storage contents are don't-care after reset.
REQ-034 Storage array has no reset; only control registers are reset.

Structure
REQ-035 Shared package holds: direction encodings (UP, RIGHT, LEFT, DOWN), FSM state encodings, and default DEPTH/AW.
REQ-036 One sub-module, path_ram: DEPTH x 2 storage, synchronous write, combinational read.
REQ-037 Control and FSM reside in path_recorder; the Move output drives the downstream move player / display.

Verification
REQ-038 Push 01,01,11,10, then Run pulse -> Move 01,01,11,10 on four consecutive cycles; Replay_done one cycle later; Count=4.
REQ-039 Push 00,01,11; Pop; Push 10 -> Count=3; replay gives 00,01,10.
REQ-040 Push 256 times, then Push 00 -> Full=1, Count=256, Overflow=1; replay gives 256 moves.
REQ-041 Empty, Push+Pop together with Dir_in=11 -> Count=1; then Push+Pop with 00 -> Count=1, replay gives 00.
REQ-042 Run with Count=0 -> Replay_done pulse 2 cycles after Run; Move_valid never asserted.
REQ-043 RST=0 low asynchronously mid-replay (third move) -> outputs clear without a clock edge; no Replay_done; Count=0.
